// File: rtl/ahb_app_arbiter.sv
// ahb_app_arbiter: shares one AHB-Lite master application port between
// N_REQ requesters; latches the winner's command and sequences its beats.
// Ports:
//   HCLK/HRESETn           clock, async active-low reset
//   req/req_write/req_size/req_addr/req_len/req_wdata  requester commands
//   gnt/owner/busy_o       grant pulse, current owner, command in flight
//   wr_pop/rd_valid/rd_data/done/err  per-owner data and status returns
//   m_enable/m_func/m_addr/m_data_in/m_busy  master command side
//   m_data_out/m_data_valid/m_error/m_wait   master response side
// AHB_ARB_RR_EN: round-robin when defined, else fixed lowest-index priority.
module ahb_app_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [2*N_REQ-1:0]     req_size,
  input  logic [32*N_REQ-1:0]    req_addr,
  input  logic [LEN_W*N_REQ-1:0] req_len,
  input  logic [32*N_REQ-1:0]    req_wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [2:0]             owner,
  output logic                   busy_o,
  output logic [N_REQ-1:0]       wr_pop,
  output logic [N_REQ-1:0]       rd_valid,
  output logic [31:0]            rd_data,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   m_enable,
  output logic [4:0]             m_func,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_data_in,
  output logic                   m_busy,
  input  logic [31:0]            m_data_out,
  input  logic                   m_data_valid,
  input  logic                   m_error,
  input  logic                   m_wait
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR,
    S_BURST,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [LEN_W-1:0] L_ONE = 1;

  state_t r_state;
  state_t w_nxt;

  logic [2:0]       r_owner;
  logic             r_write;
  logic [1:0]       r_size;
  logic [31:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_pend;

  logic             w_any;
  logic [2:0]       w_win;
  logic             w_s_write;
  logic [1:0]       w_s_size;
  logic [31:0]      w_s_addr;
  logic [LEN_W-1:0] w_s_len;
  logic [31:0]      w_wdata;
  logic [N_REQ-1:0] w_oh;
  logic [31:0]      w_step;

  logic             w_grant;
  logic             w_acc;
  logic             w_fin;
  logic             w_abort;
  logic             w_dp;
  logic             w_en;
  logic [4:0]       w_func;

  assign w_any  = |req;
  assign w_step = 32'd1 << r_size;

`ifdef AHB_ARB_RR_EN
  logic [2:0] r_rr;
  logic [3:0] w_idx;
  logic       w_found;

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr} + 4'(k);
      if (w_idx >= 4'(N_REQ))
        w_idx = w_idx - 4'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!w_found && req[j] &&
            w_idx == 4'(j)) begin
          w_win   = 3'(j);
          w_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_rr <= '0;
    else if (w_grant) begin
      if (w_win == 3'(N_REQ - 1))
        r_rr <= '0;
      else
        r_rr <= w_win + 3'd1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (req[j])
        w_win = 3'(j);
  end
`endif

  // winner's command fields, and the owner's write beat
  always_comb begin
    w_s_write = 1'b0;
    w_s_size  = '0;
    w_s_addr  = '0;
    w_s_len   = '0;
    w_wdata   = '0;
    w_oh      = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_win == 3'(j)) begin
        w_s_write = req_write[j];
        w_s_size  = req_size[j*2 +: 2];
        w_s_addr  = req_addr[j*32 +: 32];
        w_s_len   = req_len[j*LEN_W +: LEN_W];
      end
      if (r_owner == 3'(j)) begin
        w_wdata = req_wdata[j*32 +: 32];
        w_oh[j] = 1'b1;
      end
    end
  end

  // a pending data phase completes on any unstalled, error-free cycle
  assign w_dp = r_pend & ~m_wait & ~m_error;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_state <= S_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_acc   = 1'b0;
    w_fin   = 1'b0;
    w_abort = 1'b0;
    w_en    = 1'b0;
    w_func  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_nxt   = S_GRANT;
        end
      end
      S_GRANT: begin
        w_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_en   = 1'b1;
        w_func = {1'b1, r_len != '0,
                  r_write, r_size};
        if (m_error) begin
          w_abort = 1'b1;
          w_en    = 1'b0;
          w_nxt   = S_ERR;
        end else if (!m_wait) begin
          w_acc = 1'b1;
          w_nxt = (r_len == '0) ? S_DRAIN
                                : S_BURST;
        end
      end
      S_BURST: begin
        w_en = 1'b1;
        // crossing a 1KB page restarts the burst as NON_SEQ
        w_func = {r_addr[9:0] == 10'd0, 1'b1,
                  r_write, r_size};
        if (m_error) begin
          w_abort = 1'b1;
          w_en    = 1'b0;
          w_nxt   = S_ERR;
        end else if (!m_wait) begin
          w_acc = 1'b1;
          if (r_cnt == r_len)
            w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_en   = 1'b1;
        w_func = {2'b00, r_write, r_size};
        if (m_error) begin
          w_abort = 1'b1;
          w_en    = 1'b0;
          w_nxt   = S_ERR;
        end else if (!m_wait) begin
          w_fin = 1'b1;
          if (w_any) begin
            w_grant = 1'b1;
            w_nxt   = S_GRANT;
          end else begin
            w_nxt = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (!m_error)
          w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_write <= w_s_write;
        r_size  <= w_s_size;
        r_addr  <= w_s_addr;
        r_len   <= w_s_len;
        r_cnt   <= '0;
      end else if (w_acc) begin
        // the last beat leaves addr and count parked
        if (r_state == S_ADDR) begin
          if (r_len != '0) begin
            r_addr <= r_addr + w_step;
            r_cnt  <= L_ONE;
          end
        end else if (r_cnt != r_len) begin
          r_addr <= r_addr + w_step;
          r_cnt  <= r_cnt + L_ONE;
        end
      end
      if (w_abort)
        r_pend <= 1'b0;
      else if (w_acc)
        r_pend <= 1'b1;
      else if (w_dp)
        r_pend <= 1'b0;
    end
  end

  assign gnt = (r_state == S_GRANT) ? w_oh : '0;
  assign owner  = r_owner;
  assign busy_o = (r_state == S_GRANT) ||
                  (r_state == S_ADDR)  ||
                  (r_state == S_BURST) ||
                  (r_state == S_DRAIN);

  assign wr_pop = (w_dp && r_write) ? w_oh : '0;
  assign rd_valid = (w_dp && !r_write &&
                     m_data_valid) ? w_oh : '0;
  assign rd_data = (w_dp && !r_write) ?
                   m_data_out : '0;
  assign done = w_fin   ? w_oh : '0;
  assign err  = w_abort ? w_oh : '0;

  assign m_enable  = w_en;
  assign m_func    = w_func;
  assign m_addr    = w_en ? r_addr : '0;
  assign m_data_in = (r_pend && r_write) ?
                     w_wdata : '0;
  assign m_busy    = 1'b0;

endmodule

// File: tb/tb_ahb_app_arbiter.sv
// tb_ahb_app_arbiter: directed-vector bench for ahb_app_arbiter.
// Acts as requesters and as the master/slave response side.
module tb_ahb_app_arbiter;

  logic         HCLK;
  logic         HRESETn;
  logic [3:0]   req;
  logic [3:0]   req_write;
  logic [7:0]   req_size;
  logic [127:0] req_addr;
  logic [15:0]  req_len;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic [2:0]   owner;
  logic         busy_o;
  logic [3:0]   wr_pop;
  logic [3:0]   rd_valid;
  logic [31:0]  rd_data;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         m_enable;
  logic [4:0]   m_func;
  logic [31:0]  m_addr;
  logic [31:0]  m_data_in;
  logic         m_busy;
  logic [31:0]  m_data_out;
  logic         m_data_valid;
  logic         m_error;
  logic         m_wait;

  int n_chk;
  int n_pass;
  int pops;
  int rds;
  logic [31:0] wd;
  logic [3:0]  exp_g [4];

  ahb_app_arbiter dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (req),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .owner        (owner),
    .busy_o       (busy_o),
    .wr_pop       (wr_pop),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .done         (done),
    .err          (err),
    .m_enable     (m_enable),
    .m_func       (m_func),
    .m_addr       (m_addr),
    .m_data_in    (m_data_in),
    .m_busy       (m_busy),
    .m_data_out   (m_data_out),
    .m_data_valid (m_data_valid),
    .m_error      (m_error),
    .m_wait       (m_wait)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge HCLK);
    #2;
  endtask

  task automatic set_cmd(input int i,
                         input logic w,
                         input logic [1:0] sz,
                         input logic [31:0] a,
                         input logic [3:0] l);
    req_write[i]      = w;
    req_size[i*2+:2]  = sz;
    req_addr[i*32+:32] = a;
    req_len[i*4+:4]   = l;
  endtask

  task automatic set_wd(input int i,
                        input logic [31:0] d);
    req_wdata[i*32+:32] = d;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    HRESETn = 1'b0;
    req = '0;
    req_write = '0;
    req_size = '0;
    req_addr = '0;
    req_len = '0;
    req_wdata = '0;
    m_data_out = '0;
    m_data_valid = 1'b0;
    m_error = 1'b0;
    m_wait = 1'b0;
`ifdef AHB_ARB_RR_EN
    exp_g = '{4'b0001, 4'b0010,
              4'b0100, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0001,
              4'b0001, 4'b0001};
`endif

    // reset state
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_en", m_enable, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_mbusy", m_busy, 0);
    HRESETn = 1'b1;
    tick;

    // three len-0 requesters held continuously
    for (int i = 0; i < 3; i++)
      set_cmd(i, 1'b0, 2'b10,
              32'h40 * i, 4'd0);
    req = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      tick;
      #1;
      chk("s3_gnt", gnt, exp_g[k]);
      tick;
      tick;
      #1;
      chk("s3_done", done, exp_g[k]);
      if (k == 3)
        req = '0;
    end
    tick;
    #1;
    chk("s3_idle", busy_o, 0);

    // single word read
    set_cmd(0, 1'b0, 2'b10, 32'h100, 4'd0);
    req = 4'b0001;
    #1;
    chk("s1_busy0", busy_o, 0);
    tick;
    req = '0;
    #1;
    chk("s1_gnt", gnt, 4'b0001);
    chk("s1_en0", m_enable, 0);
    tick;
    #1;
    chk("s1_func", m_func, 5'b10010);
    chk("s1_addr", m_addr, 32'h100);
    chk("s1_en", m_enable, 1);
    tick;
    m_data_valid = 1'b1;
    m_data_out = 32'hDEADBEEF;
    #1;
    chk("s1_rdv", rd_valid, 4'b0001);
    chk("s1_rdd", rd_data, 32'hDEADBEEF);
    chk("s1_done", done, 4'b0001);
    tick;
    m_data_valid = 1'b0;
    #1;
    chk("s1_busy1", busy_o, 0);
    chk("s1_done1", done, 0);

    // 4-beat INCR write
    set_cmd(1, 1'b1, 2'b10, 32'h200, 4'd3);
    wd = 32'hA000_0000;
    set_wd(1, wd);
    req = 4'b0010;
    pops = 0;
    tick;
    req = '0;
    #1;
    chk("s2_gnt", gnt, 4'b0010);
    chk("s2_owner", owner, 1);
    tick;
    #1;
    chk("s2_func0", m_func, 5'b11110);
    chk("s2_addr0", m_addr, 32'h200);
    chk("s2_pop0", wr_pop, 0);
    for (int b = 1; b < 4; b++) begin
      tick;
      #1;
      chk("s2_addr", m_addr,
          32'h200 + 32'(4 * b));
      chk("s2_func", m_func, 5'b01110);
      chk("s2_din", m_data_in, wd);
      chk("s2_pop", wr_pop, 4'b0010);
      if (wr_pop[1])
        pops++;
      wd = wd + 1;
      set_wd(1, wd);
    end
    tick;
    #1;
    chk("s2_dfunc", m_func, 5'b00110);
    chk("s2_ddin", m_data_in, wd);
    chk("s2_dpop", wr_pop, 4'b0010);
    chk("s2_done", done, 4'b0010);
    if (wr_pop[1])
      pops++;
    tick;
    #1;
    chk("s2_busy", busy_o, 0);
    chk("s2_pops", pops, 4);

    // 4-beat read with 3 wait cycles on beat 2
    set_cmd(2, 1'b0, 2'b10, 32'h300, 4'd3);
    req = 4'b0100;
    m_data_valid = 1'b1;
    m_data_out = 32'h5000_0000;
    rds = 0;
    tick;
    req = '0;
    #1;
    chk("s4_gnt", gnt, 4'b0100);
    tick;
    #1;
    chk("s4_addr0", m_addr, 32'h300);
    chk("s4_rdv0", rd_valid, 0);
    tick;
    #1;
    chk("s4_addr1", m_addr, 32'h304);
    chk("s4_rdv1", rd_valid, 4'b0100);
    chk("s4_rdd1", rd_data, 32'h5000_0000);
    if (rd_valid[2])
      rds++;
    tick;
    m_wait = 1'b1;
    m_data_out = 32'h5000_0001;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("s4_waddr", m_addr, 32'h308);
      chk("s4_wfunc", m_func, 5'b01010);
      chk("s4_wen", m_enable, 1);
      chk("s4_wrdv", rd_valid, 0);
      tick;
    end
    m_wait = 1'b0;
    #1;
    chk("s4_addr2", m_addr, 32'h308);
    chk("s4_rdv2", rd_valid, 4'b0100);
    chk("s4_rdd2", rd_data, 32'h5000_0001);
    if (rd_valid[2])
      rds++;
    tick;
    m_data_out = 32'h5000_0002;
    #1;
    chk("s4_addr3", m_addr, 32'h30C);
    chk("s4_rdd3", rd_data, 32'h5000_0002);
    if (rd_valid[2])
      rds++;
    tick;
    m_data_out = 32'h5000_0003;
    #1;
    chk("s4_dfunc", m_func, 5'b00010);
    chk("s4_done", done, 4'b0100);
    if (rd_valid[2])
      rds++;
    tick;
    m_data_valid = 1'b0;
    #1;
    chk("s4_busy", busy_o, 0);
    chk("s4_rds", rds, 4);

    // slave error on beat 2 of a 4-beat write
    set_cmd(1, 1'b1, 2'b10, 32'h500, 4'd3);
    set_wd(1, 32'hB0);
    set_cmd(3, 1'b0, 2'b10, 32'h600, 4'd0);
    req = 4'b0010;
    tick;
    req = 4'b1000;
    #1;
    chk("s5_gnt", gnt, 4'b0010);
    tick;
    #1;
    chk("s5_addr0", m_addr, 32'h500);
    tick;
    #1;
    chk("s5_addr1", m_addr, 32'h504);
    chk("s5_pop", wr_pop, 4'b0010);
    tick;
    m_error = 1'b1;
    #1;
    chk("s5_err", err, 4'b0010);
    chk("s5_en", m_enable, 0);
    chk("s5_done", done, 0);
    chk("s5_epop", wr_pop, 0);
    tick;
    #1;
    chk("s5_err1", err, 0);
    chk("s5_en1", m_enable, 0);
    chk("s5_ebusy", busy_o, 0);
    tick;
    m_error = 1'b0;
    #1;
    chk("s5_gnt1", gnt, 0);
    chk("s5_err2", err, 0);
    tick;
    #1;
    chk("s5_gnt2", gnt, 0);
    tick;
    req = '0;
    #1;
    chk("s5_gnt3", gnt, 4'b1000);
    tick;
    #1;
    chk("s5_addr3", m_addr, 32'h600);
    chk("s5_func3", m_func, 5'b10010);
    tick;
    #1;
    chk("s5_done3", done, 4'b1000);
    chk("s5_err3", err, 0);
    tick;

    // 1KB crossing, then reset mid-burst
    set_cmd(0, 1'b0, 2'b10, 32'h3F8, 4'd3);
    req = 4'b0001;
    tick;
    req = '0;
    #1;
    chk("s6_gnt", gnt, 4'b0001);
    tick;
    #1;
    chk("s6_addr0", m_addr, 32'h3F8);
    chk("s6_func0", m_func, 5'b11010);
    tick;
    #1;
    chk("s6_addr1", m_addr, 32'h3FC);
    chk("s6_func1", m_func, 5'b01010);
    tick;
    #1;
    chk("s6_addr2", m_addr, 32'h400);
    chk("s6_func2", m_func, 5'b11010);
    tick;
    #1;
    chk("s6_addr3", m_addr, 32'h404);
    chk("s6_func3", m_func, 5'b01010);
    HRESETn = 1'b0;
    #1;
    chk("s6_ren", m_enable, 0);
    chk("s6_rfunc", m_func, 0);
    chk("s6_raddr", m_addr, 0);
    chk("s6_rbusy", busy_o, 0);
    chk("s6_rowner", owner, 0);
    #2;
    HRESETn = 1'b1;
    tick;
    #1;
    chk("s6_idle", busy_o, 0);
    chk("s6_ien", m_enable, 0);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
